// File: rtl/bit_level_mixing_engine.sv
// Iterative per-lane rotate mixer: LANES x LANE_W word, ROUNDS key-driven rotations, valid/ready on both sides.
// Optional BLM_ROUND_TWEAK_EN adds the round index to each lane's rotate amount.

module blm_lane #(
  parameter int LANE_W = 8,
  parameter int SH_W   = 3
) (
  input  logic [LANE_W-1:0] v,
  input  logic [SH_W-1:0]   amt,
  input  logic              mode,
  output logic [LANE_W-1:0] y
);
  // Rotating a doubled copy keeps the shift below LANE_W's worth of wrap and makes amt=0 a no-op.
  always_comb begin
    if (mode) y = LANE_W'(({v, v} << amt) >> LANE_W);
    else      y = LANE_W'({v, v} >> amt);
  end
endmodule

module bit_level_mixing_engine #(
  parameter int LANE_W = 8,
  parameter int LANES  = 8,
  parameter int ROUNDS = 1,
  parameter int SH_W   = $clog2(LANE_W)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      mode,
  input  logic [0:LANES*LANE_W-1]   data_in,
  input  logic [0:LANES*LANE_W-1]   key_in,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [0:LANES*LANE_W-1]   data_out,
  output logic                      busy
);
  localparam int W   = LANES * LANE_W;
  localparam int R_W = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t                       state;
  logic [0:W-1]                 work;
  logic [0:W-1]                 work_next;
  logic [LANES-1:0][SH_W-1:0]   key_q;
  logic [LANES-1:0][SH_W-1:0]   amt;
  logic                         mode_q;
  logic [R_W-1:0]               r;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
`ifdef BLM_ROUND_TWEAK_EN
    assign amt[i] = key_q[i] + SH_W'(r);
`else
    assign amt[i] = key_q[i];
`endif
    blm_lane #(.LANE_W(LANE_W), .SH_W(SH_W)) u_lane (
      .v   (work[i*LANE_W +: LANE_W]),
      .amt (amt[i]),
      .mode(mode_q),
      .y   (work_next[i*LANE_W +: LANE_W])
    );
  end

  // DONE spends its first cycle loading data_out, so out_valid appears ROUNDS+1 clocks after accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      data_out  <= '0;
      work      <= '0;
      key_q     <= '0;
      mode_q    <= 1'b0;
      r         <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          work   <= data_in;
          mode_q <= mode;
          for (int i = 0; i < LANES; i++)
            key_q[i] <= key_in[i*LANE_W + LANE_W - SH_W +: SH_W];
          r        <= '0;
          state    <= BUSY;
          in_ready <= 1'b0;
          busy     <= 1'b1;
        end
        BUSY: begin
          work <= work_next;
          r    <= r + 1'b1;
          if (r == R_W'(ROUNDS - 1)) state <= DONE;
        end
        DONE: begin
          if (!out_valid) begin
            out_valid <= 1'b1;
            data_out  <= work;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bit_level_mixing_engine.sv
// Bench for bit_level_mixing_engine: four instances with ROUNDS=1..4, table vectors, scoreboard, corner sequences.
module tb_bit_level_mixing_engine;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid [4];
  logic        in_ready [4];
  logic        mode     [4];
  logic [0:63] data_in  [4];
  logic [0:63] key_in   [4];
  logic        out_valid[4];
  logic        out_ready[4];
  logic [0:63] data_out [4];
  logic        busy     [4];

  int n_cmp = 0;
  int n_bad = 0;
  logic [63:0] exp_q[$];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    bit_level_mixing_engine #(.LANE_W(8), .LANES(8), .ROUNDS(g + 1)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid[g]), .in_ready(in_ready[g]), .mode(mode[g]),
      .data_in(data_in[g]), .key_in(key_in[g]),
      .out_valid(out_valid[g]), .out_ready(out_ready[g]),
      .data_out(data_out[g]), .busy(busy[g])
    );
  end

  typedef struct {
    int          k;
    bit          m;
    logic [63:0] d;
    logic [63:0] key;
    logic [63:0] exp;
    string       nm;
  } vec_t;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference rotate: output bit index formulation, lane 0 in the top byte.
  function automatic logic [63:0] model(input logic [63:0] d, input logic [63:0] key,
                                        input bit m, input int rounds);
    logic [63:0] res;
    logic [7:0]  ln, kl, nx;
    int a;
    res = d;
    for (int r = 0; r < rounds; r++)
      for (int i = 0; i < 8; i++) begin
        ln = res[63-8*i -: 8];
        kl = key[63-8*i -: 8];
        a  = int'(kl[2:0]);
`ifdef BLM_ROUND_TWEAK_EN
        a  = (a + r) % 8;
`endif
        for (int j = 0; j < 8; j++) begin
          if (m) nx[(j + a) % 8] = ln[j];
          else   nx[j] = ln[(j + a) % 8];
        end
        res[63-8*i -: 8] = nx;
      end
    return res;
  endfunction

  task automatic wait_ready(input int k, input string nm);
    int n = 0;
    while (!in_ready[k] && n < 40) begin @(posedge clk); #1; n++; end
    if (!in_ready[k]) check({nm, "_ready_timeout"}, 64'(in_ready[k]), 64'd1);
  endtask

  // Accept one word, expect out_valid at ROUNDS+1 clocks, compare against the queued expectation.
  task automatic run_word(input int k, input bit m, input logic [63:0] d,
                          input logic [63:0] key, input logic [63:0] exp, input string nm);
    int lat = 0;
    logic [63:0] e;
    wait_ready(k, nm);
    in_valid[k] = 1'b1; mode[k] = m; data_in[k] = d; key_in[k] = key;
    exp_q.push_back(exp);
    @(posedge clk); #1;
    in_valid[k] = 1'b0;
    while (!out_valid[k] && lat < 40) begin @(posedge clk); #1; lat++; end
    if (!out_valid[k]) begin
      check({nm, "_timeout"}, 64'(out_valid[k]), 64'd1);
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      return;
    end
    check({nm, "_latency"}, 64'(lat), 64'(k + 2));
    e = exp_q.pop_front();
    check(nm, data_out[k], e);
    @(posedge clk); #1;
  endtask

  vec_t tv[8];
  logic [63:0] d, key, enc, held;
  int seen;

  initial begin
    foreach (in_valid[k]) begin
      in_valid[k] = 1'b0; mode[k] = 1'b0; out_ready[k] = 1'b1;
      data_in[k] = '0; key_in[k] = '0;
    end
    rst = 1'b1;

    tv[0] = '{0, 1'b1, 64'h81A5A5A5A5A5A5A5, 64'h0100000000000000, 64'h03A5A5A5A5A5A5A5, "dec_r1"};
    tv[1] = '{0, 1'b0, 64'h81A5A5A5A5A5A5A5, 64'h0100000000000000, 64'hC0A5A5A5A5A5A5A5, "enc_r1"};
    tv[2] = '{0, 1'b0, 64'h81A5A5A5A5A5A5A5, 64'h0800000000000000, 64'h81A5A5A5A5A5A5A5, "enc_amt0"};
`ifdef BLM_ROUND_TWEAK_EN
    tv[3] = '{2, 1'b0, 64'h0100000000000000, 64'h0100000000000000, 64'h0400000000000000, "enc_r3"};
    tv[4] = '{2, 1'b1, 64'h0400000000000000, 64'h0100000000000000, 64'h0100000000000000, "dec_r3"};
    tv[5] = '{1, 1'b0, 64'h0123456789ABCDEF, 64'h0001020304050607, 64'h80642ACEC4756EDF, "enc_r2_lanes"};
`else
    tv[3] = '{2, 1'b0, 64'h0100000000000000, 64'h0100000000000000, 64'h2000000000000000, "enc_r3"};
    tv[4] = '{2, 1'b1, 64'h2000000000000000, 64'h0100000000000000, 64'h0100000000000000, "dec_r3"};
    tv[5] = '{1, 1'b0, 64'h0123456789ABCDEF, 64'h0001020304050607, 64'h01C8549D89EADCBF, "enc_r2_lanes"};
`endif
    tv[6] = '{3, 1'b0, 64'hFFFFFFFFFFFFFFFF, 64'h0706050403020100, 64'hFFFFFFFFFFFFFFFF, "enc_ones"};
    tv[7] = '{0, 1'b1, 64'h8000000000000001, 64'h0700000000000007, 64'h4000000000000080, "dec_amt7"};

    #12;
    for (int k = 0; k < 4; k++) begin
      check("rst_in_ready", 64'(in_ready[k]), 64'd1);
      check("rst_out_valid", 64'(out_valid[k]), 64'd0);
      check("rst_busy", 64'(busy[k]), 64'd0);
      check("rst_data_out", data_out[k], 64'd0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    foreach (tv[v]) run_word(tv[v].k, tv[v].m, tv[v].d, tv[v].key, tv[v].exp, tv[v].nm);

    for (int v = 0; v < 1000; v++) begin
      d   = {$urandom, $urandom};
      key = {$urandom, $urandom};
      enc = model(d, key, 1'b0, (v % 4) + 1);
      run_word(v % 4, 1'b0, d, key, enc, "rt_enc");
      run_word(v % 4, 1'b1, enc, key, d, "rt_dec");
    end

    // Back-pressure on the ROUNDS=1 instance: result held, new inputs ignored.
    out_ready[0] = 1'b0;
    wait_ready(0, "bp");
    in_valid[0] = 1'b1; mode[0] = 1'b1;
    data_in[0] = 64'h81A5A5A5A5A5A5A5; key_in[0] = 64'h0100000000000000;
    exp_q.push_back(64'h03A5A5A5A5A5A5A5);
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    seen = 0;
    while (!out_valid[0] && seen < 40) begin @(posedge clk); #1; seen++; end
    held = exp_q.pop_front();
    check("bp_first", data_out[0], held);
    for (int c = 0; c < 10; c++) begin
      in_valid[0] = c[0];
      data_in[0] = {$urandom, $urandom};
      key_in[0] = {$urandom, $urandom};
      @(posedge clk); #1;
      check("bp_data", data_out[0], held);
      check("bp_out_valid", 64'(out_valid[0]), 64'd1);
      check("bp_in_ready", 64'(in_ready[0]), 64'd0);
      check("bp_busy", 64'(busy[0]), 64'd1);
    end
    in_valid[0] = 1'b0;
    out_ready[0] = 1'b1;
    @(posedge clk); #1;
    check("bp_release_valid", 64'(out_valid[0]), 64'd0);
    check("bp_release_ready", 64'(in_ready[0]), 64'd1);
    run_word(0, 1'b0, 64'h81A5A5A5A5A5A5A5, 64'h0100000000000000, 64'hC0A5A5A5A5A5A5A5, "bp_next");

    // Abort a ROUNDS=4 word at r=2; data_out still holds the previous result here.
    wait_ready(3, "rst_mid");
    in_valid[3] = 1'b1; mode[3] = 1'b0;
    data_in[3] = 64'h0123456789ABCDEF; key_in[3] = 64'h0101010101010101;
    @(posedge clk); #1;
    in_valid[3] = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("mid_busy", 64'(busy[3]), 64'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_out_valid", 64'(out_valid[3]), 64'd0);
    check("mid_rst_busy", 64'(busy[3]), 64'd0);
    check("mid_rst_data_out", data_out[3], 64'd0);
    check("mid_rst_in_ready", 64'(in_ready[3]), 64'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      if (out_valid[3]) seen++;
    end
    check("mid_no_partial", 64'(seen), 64'd0);
    d = 64'h0123456789ABCDEF; key = 64'h0101010101010101;
    run_word(3, 1'b0, d, key, model(d, key, 1'b0, 4), "mid_next");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
